axi4_lite_read_arbiter: RTL and testbench

Round-robin arbiter that shares one AXI4-Lite read subordinate (the register-file read port) between `REQUESTERS` AXI4-Lite read managers. It sits between the interconnect-side managers and the single downstream read subordinate, and keeps at most one read outstanding. It routes each response back to the manager that issued the address. An optional response register slice is selectable at compile time.

---
 rtl/axi4_lite_read_arbiter.sv | 153 +++++++++++++++
 tb/tb_axi4_lite_read_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_read_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite read subordinate between REQUESTERS managers.
// Define AXI4_LITE_READ_ARBITER_RSLICE_EN to register the response path (adds the RESP state).
module axi4_lite_read_arbiter #(
    parameter int ADDRESS_SIZE = 32,
    parameter int DATA_SIZE    = 32,
    parameter int REQUESTERS   = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_clk_i,
    input  logic [REQUESTERS*ADDRESS_SIZE-1:0] s_araddr_i,
    input  logic [REQUESTERS-1:0]              s_arvalid_i,
    output logic [REQUESTERS-1:0]              s_arready_o,
    output logic [DATA_SIZE-1:0]               s_rdata_o,
    output logic [1:0]                         s_rresp_o,
    output logic [REQUESTERS-1:0]              s_rvalid_o,
    input  logic [REQUESTERS-1:0]              s_rready_i,
    output logic [ADDRESS_SIZE-1:0]            m_araddr_o,
    output logic                               m_arvalid_o,
    input  logic                               m_arready_i,
    input  logic [DATA_SIZE-1:0]               m_rdata_i,
    input  logic [1:0]                         m_rresp_i,
    input  logic                               m_rvalid_i,
    output logic                               m_rready_o,
    output logic [REQUESTERS-1:0]              grant_o
);
    localparam int          IDX_W = $clog2(REQUESTERS);
    localparam int unsigned NREQ  = REQUESTERS;

`ifdef AXI4_LITE_READ_ARBITER_RSLICE_EN
    typedef enum logic [2:0] {IDLE, ACCEPT, ADDR, DATA, RESP} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACCEPT, ADDR, DATA} state_t;
`endif

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        last_q, gidx_q, win_idx;
    logic                    win_found, rsp_done;
    logic [DATA_SIZE-1:0]    rdata_q;
    logic [1:0]              rresp_q;
    logic [ADDRESS_SIZE-1:0] req_addr [REQUESTERS];

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_addr[i] = s_araddr_i[i*ADDRESS_SIZE +: ADDRESS_SIZE];
        end
    end

    // Search begins just after the last served requester and wraps.
    always_comb begin : rr_pick
        logic [IDX_W-1:0] cand;
        cand      = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = IDX_W'((32'(last_q) + i) % NREQ);
            if (!win_found && s_arvalid_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

`ifdef AXI4_LITE_READ_ARBITER_RSLICE_EN
    assign rsp_done = (state_q == RESP) && s_rready_i[gidx_q];
`else
    assign rsp_done = (state_q == DATA) && m_rvalid_i && s_rready_i[gidx_q];
`endif

    always_ff @(posedge clk_i or posedge rst_clk_i) begin
        if (rst_clk_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (win_found) state_d = ACCEPT;
            ACCEPT: state_d = ADDR;
            ADDR:   if (m_arready_i) state_d = DATA;
`ifdef AXI4_LITE_READ_ARBITER_RSLICE_EN
            DATA:   if (m_rvalid_i) state_d = RESP;
            RESP:   if (rsp_done) state_d = IDLE;
`else
            DATA:   if (rsp_done) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_clk_i) begin
        if (rst_clk_i) begin
            last_q      <= IDX_W'(REQUESTERS - 1);
            gidx_q      <= '0;
            grant_o     <= '0;
            s_arready_o <= '0;
            m_araddr_o  <= '0;
            rdata_q     <= '0;
            rresp_q     <= '0;
        end else begin
            s_arready_o <= '0;
            if (state_q == IDLE && win_found) begin
                gidx_q      <= win_idx;
                grant_o     <= REQUESTERS'(1) << win_idx;
                s_arready_o <= REQUESTERS'(1) << win_idx;
            end
            if (state_q == ACCEPT) begin
                m_araddr_o <= req_addr[gidx_q];
            end
            // Captured in both builds: it is also what s_rdata_o holds between responses.
            if (state_q == DATA && m_rvalid_i) begin
                rdata_q <= m_rdata_i;
                rresp_q <= m_rresp_i;
            end
            if (rsp_done) begin
                last_q  <= gidx_q;
                grant_o <= '0;
            end
        end
    end

    always_comb begin
        m_arvalid_o = (state_q == ADDR);
        m_rready_o  = 1'b0;
        s_rvalid_o  = '0;
        s_rdata_o   = rdata_q;
        s_rresp_o   = rresp_q;
`ifdef AXI4_LITE_READ_ARBITER_RSLICE_EN
        if (state_q == DATA) begin
            m_rready_o = 1'b1;
        end
        if (state_q == RESP) begin
            s_rvalid_o[gidx_q] = 1'b1;
        end
`else
        if (state_q == DATA) begin
            s_rvalid_o[gidx_q] = m_rvalid_i;
            m_rready_o         = s_rready_i[gidx_q];
            if (m_rvalid_i) begin
                s_rdata_o = m_rdata_i;
                s_rresp_o = m_rresp_i;
            end
        end
`endif
    end

    // The granted manager must keep arvalid up through its ACCEPT cycle.
    a_hold_arvalid : assert property (@(posedge clk_i) disable iff (rst_clk_i)
        (state_q == ACCEPT) |-> s_arvalid_i[gidx_q]);

endmodule

// File: tb/tb_axi4_lite_read_arbiter.sv
// Bench for axi4_lite_read_arbiter: vector table of read transactions with a response scoreboard.
// Expected latencies follow AXI4_LITE_READ_ARBITER_RSLICE_EN when it is defined for the build.
module tb_axi4_lite_read_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 2;
`ifdef AXI4_LITE_READ_ARBITER_RSLICE_EN
    localparam int SLICE = 1;
`else
    localparam int SLICE = 0;
`endif

    logic           clk_i = 1'b0;
    logic           rst_clk_i;
    logic [NR*AW-1:0] s_araddr_i;
    logic [NR-1:0]  s_arvalid_i, s_arready_o, s_rvalid_o, s_rready_i, grant_o;
    logic [DW-1:0]  s_rdata_o, m_rdata_i;
    logic [1:0]     s_rresp_o, m_rresp_i;
    logic [AW-1:0]  m_araddr_o;
    logic           m_arvalid_o, m_arready_i, m_rvalid_i, m_rready_o;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [NR-1:0] mask;
        logic [AW-1:0] addr0;
        logic [AW-1:0] addr1;
        int            g;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] rdata;
        logic [1:0]    rresp;
        int            ar_stall;
        int            r_stall;
        bit            chk_lat;
    } vec_t;

    typedef struct {
        int            g;
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[10];

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    axi4_lite_read_arbiter #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW), .REQUESTERS(NR)) dut (
        .clk_i(clk_i), .rst_clk_i(rst_clk_i),
        .s_araddr_i(s_araddr_i), .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o),
        .s_rdata_o(s_rdata_o), .s_rresp_o(s_rresp_o), .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i),
        .m_araddr_o(m_araddr_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
        .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i), .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o),
        .grant_o(grant_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".s_arready"}, s_arready_o, 0);
        chk({tag, ".s_rvalid"},  s_rvalid_o, 0);
        chk({tag, ".s_rdata"},   s_rdata_o, 0);
        chk({tag, ".s_rresp"},   s_rresp_o, 0);
        chk({tag, ".m_araddr"},  m_araddr_o, 0);
        chk({tag, ".m_arvalid"}, m_arvalid_o, 0);
        chk({tag, ".m_rready"},  m_rready_o, 0);
        chk({tag, ".grant"},     grant_o, 0);
    endtask

    // Called one step after a rising edge; cycle 0 is the cycle the request is raised in.
    task automatic run_vec(input vec_t v);
        int            c0, stall_left;
        logic [NR-1:0] won, oh, exp_oh;
        bit            found, seen, done, drop, rel;
        exp_t          e;
        c0 = cyc;
        oh = NR'(1) << v.g;
        if (v.mask[0]) s_araddr_i[0 +: AW] = v.addr0;
        if (v.mask[1]) s_araddr_i[AW +: AW] = v.addr1;
        s_arvalid_i = s_arvalid_i | v.mask;

        found = 0;
        won   = '0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_i);
            if (|s_arready_o) begin found = 1; won = s_arready_o; break; end
            @(posedge clk_i); #1;
        end
        if (!found) begin fail("arready_wait"); return; end
        chk("s_arready", won, oh);
        chk("grant", grant_o, oh);
        if (v.chk_lat) chk("arready_cycle", cyc - c0, 1);
        e.g = v.g; e.data = v.rdata; e.resp = v.rresp;
        sbq.push_back(e);

        @(posedge clk_i); #1;
        s_arvalid_i = s_arvalid_i & ~won;
        m_arready_i = (v.ar_stall == 0);
        for (int k = 0; k < v.ar_stall; k++) begin
            @(negedge clk_i);
            chk("stall_arvalid", m_arvalid_o, 1);
            chk("stall_araddr", m_araddr_o, v.exp_addr);
            @(posedge clk_i); #1;
        end
        m_arready_i = 1'b1;
        found = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_i);
            if (m_arvalid_o) begin found = 1; break; end
            @(posedge clk_i); #1;
        end
        if (!found) begin fail("arvalid_wait"); m_arready_i = 1'b0; return; end
        chk("m_araddr", m_araddr_o, v.exp_addr);
        if (v.chk_lat) chk("ar_handshake_cycle", cyc - c0, 2 + v.ar_stall);

        @(posedge clk_i); #1;
        m_arready_i = 1'b0;
        m_rvalid_i  = 1'b1;
        m_rdata_i   = v.rdata;
        m_rresp_i   = v.rresp;
        if (v.r_stall > 0) s_rready_i[v.g] = 1'b0;

        seen = 0; done = 0; stall_left = v.r_stall;
        for (int n = 0; n < 60 && !done; n++) begin
            @(negedge clk_i);
            drop = m_rvalid_i && m_rready_o;
            rel  = 0;
            if (|s_rvalid_o) begin
                if (!seen) begin
                    seen = 1;
                    if (v.chk_lat) chk("rvalid_cycle", cyc - c0, 3 + v.ar_stall + SLICE);
                end
                if (stall_left > 0) begin
                    chk("held_rvalid", s_rvalid_o, oh);
                    chk("held_rdata", s_rdata_o, v.rdata);
                    chk("held_m_rready", m_rready_o, 0);
                    stall_left--;
                    rel = (stall_left == 0);
                end
            end
            if (|(s_rvalid_o & s_rready_i)) begin
                if (sbq.size() == 0) begin
                    fail("unexpected_rvalid");
                end else begin
                    e = sbq.pop_front();
                    exp_oh = NR'(1) << e.g;
                    chk("rvalid_route", s_rvalid_o, exp_oh);
                    chk("rdata", s_rdata_o, e.data);
                    chk("rresp", s_rresp_o, e.resp);
                end
            end
            if (seen && grant_o == '0) begin
                done = 1;
                if (v.chk_lat) chk("idle_cycle", cyc - c0, 4 + v.ar_stall + v.r_stall + SLICE);
            end else begin
                @(posedge clk_i); #1;
                if (drop) m_rvalid_i = 1'b0;
                if (rel) s_rready_i[v.g] = 1'b1;
            end
        end
        if (!done) begin fail("response_wait"); m_rvalid_i = 1'b0; s_rready_i = '1; end
        chk("idle_rvalid", s_rvalid_o, 0);
        chk("idle_hold_rdata", s_rdata_o, v.rdata);
        chk("idle_hold_rresp", s_rresp_o, v.rresp);
        chk("scoreboard_empty", sbq.size(), 0);
        @(posedge clk_i); #1;
    endtask

    task automatic mid_data_reset();
        bit found;
        s_araddr_i[0 +: AW] = 32'h300;
        s_arvalid_i[0] = 1'b1;
        found = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_i);
            if (s_arready_o[0]) begin found = 1; break; end
            @(posedge clk_i); #1;
        end
        if (!found) fail("reset_seq_arready");
        @(posedge clk_i); #1;
        s_arvalid_i[0] = 1'b0;
        m_arready_i = 1'b1;
        found = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_i);
            if (m_arvalid_o) begin found = 1; break; end
            @(posedge clk_i); #1;
        end
        if (!found) fail("reset_seq_arvalid");
        @(posedge clk_i); #1;
        m_arready_i   = 1'b0;
        m_rvalid_i    = 1'b1;
        m_rdata_i     = 32'hCAFE0001;
        m_rresp_i     = 2'b01;
        s_rready_i[0] = 1'b0;
        @(negedge clk_i);
        chk("pre_reset_grant", grant_o, 2'b01);
        #2 rst_clk_i = 1'b1;
        #1 check_all_zero("async_reset");
        m_rvalid_i = 1'b0;
        m_rdata_i  = '0;
        m_rresp_i  = '0;
        s_rready_i = '1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_all_zero("reset_held");
        #2 rst_clk_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //          mask   addr0       addr1       g  exp_addr    rdata          rresp ars rs lat
        vecs[0] = '{2'b01, 32'h8,      32'h0,      0, 32'h8,      32'hDEADBEEF, 2'b00, 0, 0, 1'b1};
        vecs[1] = '{2'b10, 32'h0,      32'h40,     1, 32'h40,     32'h0BADF00D, 2'b10, 0, 0, 1'b1};
        vecs[2] = '{2'b10, 32'h0,      32'h44,     1, 32'h44,     32'h12345678, 2'b00, 5, 4, 1'b1};
        vecs[3] = '{2'b01, 32'h80,     32'h0,      0, 32'h80,     32'h55AA55AA, 2'b11, 0, 0, 1'b1};
        vecs[4] = '{2'b11, 32'h100,    32'h200,    0, 32'h100,    32'hA0000001, 2'b00, 0, 0, 1'b1};
        vecs[5] = '{2'b01, 32'h104,    32'h0,      1, 32'h200,    32'hB0000001, 2'b10, 0, 0, 1'b0};
        vecs[6] = '{2'b10, 32'h0,      32'h204,    0, 32'h104,    32'hA0000002, 2'b00, 0, 0, 1'b0};
        vecs[7] = '{2'b01, 32'h108,    32'h0,      1, 32'h204,    32'hB0000002, 2'b11, 0, 0, 1'b0};
        vecs[8] = '{2'b10, 32'h0,      32'h208,    0, 32'h108,    32'hA0000003, 2'b10, 0, 0, 1'b0};
        vecs[9] = '{2'b00, 32'h0,      32'h0,      1, 32'h208,    32'hB0000003, 2'b00, 0, 0, 1'b0};

        rst_clk_i   = 1'b1;
        s_araddr_i  = '0;
        s_arvalid_i = '0;
        s_rready_i  = '1;
        m_arready_i = 1'b0;
        m_rdata_i   = '0;
        m_rresp_i   = '0;
        m_rvalid_i  = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 check_all_zero("reset");
        @(negedge clk_i);
        #2 rst_clk_i = 1'b0;
        @(posedge clk_i); #1;

        for (int i = 0; i < 10; i++) begin
            if (i == 4) mid_data_reset();
            run_vec(vecs[i]);
        end
        chk("final_pending_arvalid", s_arvalid_i, 0);
        chk("final_grant", grant_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
